i2s_rx_fifo: RTL and testbench



---
 rtl/i2s_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_i2s_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_fifo.sv
// I2S master receiver: generates SCK/WS, captures one channel slot, sign-extends
// each sample and buffers it in a FIFO presented on a valid/ready stream.

module i2s_rx_fifo #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned SAMPLE_BITS = 18,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LVL_W       = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             en,
    input  logic             chan_sel,
    input  logic             flush,
    input  logic             ovf_clr,
    input  logic [LVL_W-1:0] irq_thresh,
    output logic             SCK,
    output logic             WS,
    input  logic             SD,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FRAME  = 2 * SLOT_BITS;
    localparam int unsigned DC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BC_W   = $clog2(FRAME);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);

    logic [DC_W-1:0]        dc;
    logic [BC_W-1:0]        bc;
    logic                   chan_lat;
    logic [SAMPLE_BITS-1:0] shreg;
    logic                   cap_pend;
    logic [DATA_W-1:0]      cap_data;
    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    logic                   dc_wrap_c;
    logic                   sck_rise_c;
    logic                   sck_fall_c;
    logic [BC_W-1:0]        bc_inc_c;
    logic [BC_W-1:0]        bc_inc2_c;
    logic                   slot_c;
    logic [BC_W-1:0]        bit_idx_c;
    logic                   sel_c;
    logic                   hit_c;
    logic                   last_c;
    logic [SAMPLE_BITS-1:0] sh_next_c;
    logic [DATA_W-1:0]      sext_c;

    logic                   pop_c;
    logic                   push_c;
    logic                   full_c;
    logic                   wr_c;
    logic                   ovf_set_c;
    logic [LVL_W-1:0]       rem_c;
    logic [LVL_W-1:0]       level_n_c;
    logic [AW-1:0]          rd_n_c;
    logic [AW-1:0]          wr_n_c;
    logic [DATA_W-1:0]      head_c;

    // Bit-clock timing and slot decode
    always_comb begin
        dc_wrap_c  = (dc == DC_W'(CLK_DIV - 1));
        sck_rise_c = en && dc_wrap_c && !SCK;
        sck_fall_c = en && dc_wrap_c && SCK;
        bc_inc_c   = (bc == BC_W'(FRAME - 1)) ? '0 : bc + BC_W'(1);
        bc_inc2_c  = (bc_inc_c == BC_W'(FRAME - 1)) ? '0 : bc_inc_c + BC_W'(1);
        slot_c     = (bc >= BC_W'(SLOT_BITS));
        bit_idx_c  = slot_c ? bc - BC_W'(SLOT_BITS) : bc;
        // Channel choice is live during bc==0 so the first slot bit already sees it
        sel_c      = (bc == '0) ? chan_sel : chan_lat;
        hit_c      = sck_rise_c && (slot_c == sel_c) && (bit_idx_c < BC_W'(SAMPLE_BITS));
        last_c     = (bit_idx_c == BC_W'(SAMPLE_BITS - 1));
        sh_next_c  = SAMPLE_BITS'({shreg, SD});
        sext_c     = DATA_W'($signed(sh_next_c));
    end

    // SCK/WS generator; WS leads the slot MSB by one bit period
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dc  <= '0;
            SCK <= 1'b0;
            WS  <= 1'b0;
            bc  <= '0;
        end else if (!en) begin
            dc  <= '0;
            SCK <= 1'b0;
            WS  <= 1'b0;
            bc  <= '0;
        end else if (dc_wrap_c) begin
            dc  <= '0;
            SCK <= ~SCK;
            if (sck_fall_c) begin
                bc <= bc_inc_c;
                WS <= (bc_inc2_c >= BC_W'(SLOT_BITS));
            end
        end else begin
            dc <= dc + DC_W'(1);
        end
    end

    // Deserialiser; a completed sample is pushed on the following edge
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            chan_lat <= 1'b0;
            shreg    <= '0;
            cap_pend <= 1'b0;
            cap_data <= '0;
        end else begin
            chan_lat <= sel_c;
            if (!en) begin
                shreg <= '0;
            end else if (hit_c) begin
                shreg <= sh_next_c;
            end
            cap_pend <= hit_c && last_c;
            if (hit_c && last_c) begin
                cap_data <= sext_c;
            end
        end
    end

    // FIFO control and registered head computation
    always_comb begin
        pop_c     = m_valid && m_ready;
        push_c    = cap_pend && !flush;
        full_c    = (level == LVL_W'(FIFO_DEPTH));
        wr_c      = push_c && (!full_c || pop_c);
        ovf_set_c = push_c && full_c && !pop_c;
        rem_c     = level - LVL_W'(pop_c);
        level_n_c = flush ? '0 : rem_c + LVL_W'(wr_c);
        rd_n_c    = flush ? '0 : (pop_c ? rd_ptr + AW'(1) : rd_ptr);
        wr_n_c    = flush ? '0 : (wr_c ? wr_ptr + AW'(1) : wr_ptr);
        head_c    = m_data;
        if (!flush) begin
            if (rem_c == '0) begin
                if (wr_c) begin
                    head_c = cap_data;
                end
            end else begin
                head_c = mem[rd_n_c];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= cap_data;
            end
            wr_ptr  <= wr_n_c;
            rd_ptr  <= rd_n_c;
            level   <= level_n_c;
            m_valid <= (level_n_c != '0);
            m_data  <= head_c;
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            irq <= (irq_thresh != '0) && (level >= irq_thresh);
        end
    end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Directed bench for i2s_rx_fifo: microphone model plus hand-computed expectations.

module tb_i2s_rx_fifo;

    localparam int unsigned LVL_W = 4;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic             en = 1'b0;
    logic             chan_sel = 1'b0;
    logic             flush = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [LVL_W-1:0] irq_thresh = '0;
    logic             SD = 1'b0;
    logic             m_ready = 1'b0;
    logic             SCK;
    logic             WS;
    logic [31:0]      m_data;
    logic             m_valid;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             irq;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rise_l17 = 0;
    int          fidx = 0;
    logic [5:0]  tb_bc = '0;
    logic        sck_q = 1'b0;
    logic        ramp = 1'b0;
    logic [31:0] left_fixed = '0;
    logic [31:0] right_fixed = '0;
    logic [31:0] left_w;
    logic [31:0] word;

    logic [31:0] exp_ramp [8] = '{32'h0001F000, 32'h0001F800, 32'hFFFE0000, 32'hFFFE0800,
                                  32'hFFFE1000, 32'hFFFE1800, 32'hFFFE2000, 32'hFFFE2800};

    i2s_rx_fifo #(
        .CLK_DIV(2), .SLOT_BITS(32), .SAMPLE_BITS(18), .FIFO_DEPTH(8), .LVL_W(LVL_W)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .chan_sel(chan_sel), .flush(flush),
        .ovf_clr(ovf_clr), .irq_thresh(irq_thresh), .SCK(SCK), .WS(WS), .SD(SD),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow), .irq(irq)
    );

    initial forever #5 HCLK = ~HCLK;

    // Microphone: tracks bit position from SCK falls and drives SD MSB-first per slot
    always @(posedge HCLK) begin
        #1;
        cyc = cyc + 1;
        if (!HRESETn || !en) begin
            tb_bc = '0;
            fidx  = 0;
        end else if (sck_q && !SCK) begin
            if (tb_bc == 6'd63) begin
                tb_bc = '0;
                fidx  = fidx + 1;
            end else begin
                tb_bc = tb_bc + 6'd1;
            end
        end
        if (en && !sck_q && SCK && tb_bc == 6'd17) rise_l17 = cyc;
        sck_q  = SCK;
        left_w = ramp ? {18'(32'h1F000 + 32'(fidx) * 32'h800), 14'h0} : left_fixed;
        word   = tb_bc[5] ? right_fixed : left_w;
        SD     = word[5'd31 - tb_bc[4:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic restart(input logic cs, input logic rmp);
        en = 1'b0; flush = 1'b1; m_ready = 1'b0; chan_sel = cs; ramp = rmp;
        tick(1);
        flush = 1'b0;
        tick(1);
        en = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!m_valid && k < budget) begin tick(1); k++; end
        check(tag, 32'(m_valid), 32'd1);
    endtask

    task automatic wait_level(input string tag, input int n, input int budget);
        int k = 0;
        while (level != LVL_W'(n) && k < budget) begin tick(1); k++; end
        check(tag, 32'(level), 32'(n));
    endtask

    task automatic wait_bc(input string tag, input int n, input int budget);
        int k = 0;
        while (tb_bc != 6'(n) && k < budget) begin tick(1); k++; end
        check(tag, 32'(tb_bc), 32'(n));
    endtask

    task automatic wait_sck_rise(output int c);
        logic prev = SCK;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (SCK && !prev) break;
            prev = SCK;
        end
        c = cyc;
    endtask

    task automatic wait_ws(input logic to, output int c, output int b);
        logic prev = WS;
        for (int k = 0; k < 600; k++) begin
            tick(1);
            if (WS == to && prev != to) break;
            prev = WS;
        end
        c = cyc;
        b = int'(tb_bc);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        check(tag, m_data, exp);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
    endtask

    initial begin
        int c0, r1, r2, c1, c2, c3, b1, b2, b3, cf, k;

        // Reset values
        tick(3);
        check("rst_sck", 32'(SCK), 32'd0);
        check("rst_ws", 32'(WS), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        HRESETn = 1'b1;
        tick(1);

        // Clocking
        en = 1'b1;
        tick(1);
        check("sck_pre", 32'(SCK), 32'd0);
        tick(1);
        check("sck_first", 32'(SCK), 32'd1);
        c0 = cyc;
        wait_sck_rise(r1);
        wait_sck_rise(r2);
        check("sck_per1", 32'(r1 - c0), 32'd4);
        check("sck_per2", 32'(r2 - r1), 32'd4);
        wait_ws(1'b1, c1, b1);
        check("ws_rise_bc", 32'(b1), 32'd31);
        wait_ws(1'b0, c2, b2);
        check("ws_fall_bc", 32'(b2), 32'd63);
        wait_ws(1'b1, c3, b3);
        check("ws_period", 32'(c3 - c1), 32'd256);

        // Left capture, right slot ignored
        left_fixed  = {18'h2A5A5, 14'h1555};
        right_fixed = 32'h5555_5555;
        restart(1'b0, 1'b0);
        wait_valid("cap_valid", 600);
        check("cap_lat", 32'(cyc - rise_l17), 32'd1);
        check("cap_data", m_data, 32'hFFFE_A5A5);
        cf = cyc;
        pop_chk("cap_head", 32'hFFFE_A5A5);
        check("cap_empty", 32'(level), 32'd0);
        wait_valid("cap_valid2", 600);
        check("cap_period", 32'(cyc - cf), 32'd256);
        check("cap_data2", m_data, 32'hFFFE_A5A5);
        check("cap_level", 32'(level), 32'd1);

        // Right capture and chan_sel change deferred to bc==0
        left_fixed  = 32'hDEAD_BEEF;
        right_fixed = {18'h01234, 14'h3FFF};
        restart(1'b1, 1'b0);
        wait_valid("r_valid", 600);
        pop_chk("r_data", 32'h0000_1234);
        wait_bc("r_bc5", 5, 400);
        chan_sel = 1'b0;
        wait_level("r_lvl2", 2, 600);
        pop_chk("r_keep", 32'h0000_1234);
        pop_chk("r_switch", 32'hFFFF_7AB6);

        // Overflow: nine frames into eight entries
        restart(1'b0, 1'b1);
        k = 0;
        while (!overflow && k < 2700) begin tick(1); k++; end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd8);
        en = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_pop%0d", i), exp_ramp[i]);
        check("ovf_drained", 32'(level), 32'd0);
        check("ovf_novalid", 32'(m_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Interrupt threshold and flush
        irq_thresh = 4'd3;
        restart(1'b0, 1'b1);
        wait_level("irq_lvl3", 3, 900);
        check("irq_pre", 32'(irq), 32'd0);
        tick(1);
        check("irq_set", 32'(irq), 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("fl_level", 32'(level), 32'd0);
        check("fl_valid", 32'(m_valid), 32'd0);
        check("irq_lag", 32'(irq), 32'd1);
        tick(1);
        check("irq_clr", 32'(irq), 32'd0);
        irq_thresh = 4'd0;
        wait_level("irq_lvl1", 1, 400);
        tick(2);
        check("irq_dis", 32'(irq), 32'd0);

        // Disable mid-frame, then re-enable
        left_fixed = {18'h2A5A5, 14'h0};
        restart(1'b0, 1'b0);
        wait_bc("dis_bc10", 10, 100);
        en = 1'b0;
        tick(2);
        check("dis_sck", 32'(SCK), 32'd0);
        check("dis_ws", 32'(WS), 32'd0);
        tick(300);
        check("dis_nopush", 32'(level), 32'd0);
        left_fixed = {18'h15555, 14'h2AAA};
        en = 1'b1;
        wait_valid("re_valid", 400);
        check("re_lat", 32'(cyc - rise_l17), 32'd1);
        check("re_data", m_data, 32'h0001_5555);

        // Asynchronous reset mid-frame
        wait_bc("rst_bc40", 40, 400);
        check("pre_rst_ws", 32'(WS), 32'd1);
        #3;
        HRESETn = 1'b0;
        #1;
        check("arst_sck", 32'(SCK), 32'd0);
        check("arst_ws", 32'(WS), 32'd0);
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_data", m_data, 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        @(negedge HCLK);
        en = 1'b0;
        HRESETn = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
